fttenc: RTL and testbench
=========================

FTTENC -- requirements
Module: fttenc

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  rising-edge clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset; sampled only on posedge clk.
REQ-004 a  input  1  request line 0 (lowest priority).
REQ-005 b  input  1  request line 1.
REQ-006 c  input  1  request line 2.
REQ-007 d  input  1  request line 3 (highest priority).
REQ-008 e0  output  1  encoded index, bit 0, registered.
REQ-009 e1  output  1  encoded index, bit 1, registered.

Function
REQ-010 The block SHALL be a 4-to-2 priority encoder with registered outputs.
REQ-011 The encoded index {e1,e0} SHALL be the index of the highest-numbered asserted input, with d > c > b > a.
REQ-012 The next-state equations SHALL be: e1 = c | d; e0 = d | (b & ~c).
REQ-013 Input-to-index mapping SHALL be:
- d=1 -> 11
- d=0, c=1 -> 10
- d=0, c=0, b=1 -> 01
- otherwise -> 00
REQ-014 All-zero input SHALL encode to 00, identical to a=1 alone; no separate valid flag is provided.
REQ-015 Latency SHALL be exactly one clock.
- Inputs present before posedge N appear on {e1,e0} after posedge N.
- Outputs hold until the next posedge.
REQ-016 Inputs SHALL be sampled only at posedge clk. Glitches between edges SHALL NOT affect the outputs.
REQ-017 Multiple simultaneous asserted inputs SHALL resolve strictly by REQ-011. The result SHALL be deterministic with no X propagation.
REQ-018 The block SHALL have no combinational path from any input to e0 or e1.
REQ-019 Outputs SHALL be driven directly from flip-flops.

Reset
REQ-020 While rst=1 at posedge clk, e1 and e0 SHALL both load 0, regardless of a, b, c, d.
REQ-021 Reset SHALL have priority over encoding in the same cycle.
REQ-022 When rst is released, the first posedge with rst=0 SHALL load the encoding of the inputs sampled at that edge.
REQ-023 Assertion of rst mid-stream SHALL clear the outputs at that edge. No prior state SHALL persist after reset.
REQ-024 Power-up state before the first reset is unspecified. Benches SHALL apply rst for at least 1 cycle before checking.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Scenario 1, reset: rst=1, abcd=1111, 2 cycles -> e1e0=00 at each edge.
- Scenario 2, exhaustive sweep: rst=0, drive all 16 combinations of {d,c,b,a}, one per cycle -> e1e0 one cycle later matches REQ-013 (e.g. 0001->00, 0010->01, 0110->10, 1011->11).
- Scenario 3, one-hot walk: a, b, c, d each asserted alone -> 00, 01, 10, 11 respectively, each one cycle after drive.
- Scenario 4, priority conflict: abcd = b+c=1 -> 10; b+d=1 -> 11; a+b=1 -> 01.
- Scenario 5, reset mid-operation: d=1, outputs at 11, then assert rst for one edge -> 00; deassert with d still 1 -> 11 on the next edge.
- Scenario 6, latency/glitch: toggle c high then low between two posedges -> outputs unchanged; change inputs right after an edge -> outputs change only at the following edge.

Source files
------------

// File: rtl/fttenc.sv
// 4-to-2 priority encoder with registered outputs; d has the highest priority, a the lowest.
// Line a carries no information because a alone and no request both encode to 00.
module fttenc (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic e0,
    output logic e1
);

    // Returns {e1,e0} for the highest-numbered asserted request.
    function automatic logic [1:0] encode(input logic b_in, input logic c_in, input logic d_in);
        logic [1:0] idx;
        idx[1] = c_in | d_in;
        idx[0] = d_in | (b_in & ~c_in);
        return idx;
    endfunction

    logic [1:0] idx_next;
    logic       unused_a;

    assign idx_next = encode(b, c, d);
    assign unused_a = a;

    // Stage p0: inputs sampled at the edge; reset wins over encoding
    always_ff @(posedge clk) begin
        if (rst) begin
            e1 <= 1'b0;
            e0 <= 1'b0;
        end else begin
            e1 <= idx_next[1];
            e0 <= idx_next[0];
        end
    end

endmodule

// File: tb/tb_fttenc.sv
// Scoreboard bench for fttenc: the driver queues hand-computed codes, a monitor checks each edge.
module tb_fttenc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
    logic e0, e1;

    int total  = 0;
    int passed = 0;

    logic [1:0] exp_q[$];
    string      name_q[$];

    fttenc dut (
        .clk(clk),
        .rst(rst),
        .a  (a),
        .b  (b),
        .c  (c),
        .d  (d),
        .e0 (e0),
        .e1 (e1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got e1e0=%b expected %b at %0t", name, act, exp, $time);
    endtask

    // Drive at negedge, then queue the expected code for the following posedge.
    task automatic step(input logic r, input logic [3:0] dcba, input logic [1:0] exp, input string name);
        @(negedge clk);
        rst = r;
        {d, c, b, a} = dcba;
        @(posedge clk);
        exp_q.push_back(exp);
        name_q.push_back(name);
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always begin
        logic [1:0] e;
        string      n;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            check(n, {e1, e0}, e);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "timeout");
    end

    // Expected code for {d,c,b,a} = index, worked out from the priority table.
    logic [1:0] sweep_exp [16] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10,
                                   2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};

    initial begin
        // Scenario 1: reset with all requests high
        step(1'b1, 4'b1111, 2'b00, "reset_0");
        step(1'b1, 4'b1111, 2'b00, "reset_1");

        // Scenario 2: exhaustive sweep
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            step(1'b0, v, sweep_exp[i], $sformatf("sweep_%b", v));
        end

        // Scenario 3: one-hot walk (dcba)
        step(1'b0, 4'b0001, 2'b00, "onehot_a");
        step(1'b0, 4'b0010, 2'b01, "onehot_b");
        step(1'b0, 4'b0100, 2'b10, "onehot_c");
        step(1'b0, 4'b1000, 2'b11, "onehot_d");

        // Scenario 4: priority conflicts
        step(1'b0, 4'b0110, 2'b10, "prio_bc");
        step(1'b0, 4'b1010, 2'b11, "prio_bd");
        step(1'b0, 4'b0011, 2'b01, "prio_ab");

        // Scenario 5: reset mid-operation with d held high
        step(1'b0, 4'b1000, 2'b11, "mid_pre");
        step(1'b1, 4'b1000, 2'b00, "mid_rst");
        step(1'b0, 4'b1000, 2'b11, "mid_release");

        // Scenario 6a: c glitches between edges while a+b is held
        step(1'b0, 4'b0011, 2'b01, "glitch_setup");
        @(negedge clk);
        #1 c = 1'b1;
        #2 c = 1'b0;
        @(posedge clk);
        exp_q.push_back(2'b01);
        name_q.push_back("glitch_hold");

        // Scenario 6b: inputs change just after an edge; outputs must wait
        #2 {d, c, b, a} = 4'b1000;
        #3 check("late_change_hold", {e1, e0}, 2'b01);
        @(posedge clk);
        exp_q.push_back(2'b11);
        name_q.push_back("late_change_next");

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
